// File: rtl/res_bcd_pkg.sv
// Shared constants and types for the res_bcd binary-to-BCD readout stage.
package res_bcd_pkg;
   localparam int RES_W      = 32;
   localparam int RES_DIGITS = 10;
   localparam int CNT_W      = $clog2(RES_W);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
endpackage

// File: rtl/res_bcd_dig_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_dig_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);
   // Digit entering is at most 9, so the 4-bit sum never wraps
   always_comb begin
      if (d >= 4'd5) begin
         q = d + 4'd3;
      end else begin
         q = d;
      end
   end
endmodule

// File: rtl/res_bcd.sv
// Captures the LCM result on the rising edge of done_in and converts it to packed BCD.
// Optional build macro RES_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module res_bcd
   import res_bcd_pkg::*;
#(
   parameter int W      = RES_W,
   parameter int DIGITS = RES_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  done_in,
   input  logic [W-1:0]          res_in,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic                  miss
);
   state_t                state_r, state_nx_s;
   logic                  done_q_r;
   logic [W-1:0]          shreg_r;
   logic [4*DIGITS-1:0]   acc_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  busy_r, bcd_valid_r, miss_r;
   logic [4*DIGITS-1:0]   bcd_r;

   logic                  trig_s, last_s;
   logic                  start_s, shift_s, finish_s, miss_set_s;
   logic [4*DIGITS-1:0]   adj_s, acc_sh_s, final_s;
   logic [W-1:0]          shreg_sh_s;

   assign trig_s = done_in & ~done_q_r;
   assign last_s = (cnt_r == CNT_W'(W - 1));

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_dig_adj u_adj (
         .d (acc_r[4*g +: 4]),
         .q (adj_s[4*g +: 4])
      );
   end

   assign acc_sh_s   = {adj_s[4*DIGITS-2:0], shreg_r[W-1]};
   assign shreg_sh_s = {shreg_r[W-2:0], 1'b0};

`ifdef RES_BCD_BLANK_EN
   // Blank leading zeros from the top digit down; digit 0 is always shown
   function automatic logic [4*DIGITS-1:0] blank_lz(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      logic                lead;
      r    = v;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (lead && (v[4*i +: 4] == 4'h0)) begin
            r[4*i +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      return r;
   endfunction

   assign final_s = blank_lz(acc_sh_s);
`else
   assign final_s = acc_sh_s;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (trig_s) state_nx_s = SHIFT;
            else        state_nx_s = IDLE;
         end
         SHIFT: begin
            if (last_s) state_nx_s = IDLE;
            else        state_nx_s = SHIFT;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM control decode
   always_comb begin
      start_s    = 1'b0;
      shift_s    = 1'b0;
      finish_s   = 1'b0;
      miss_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            start_s = trig_s;
         end
         SHIFT: begin
            shift_s    = 1'b1;
            finish_s   = last_s;
            miss_set_s = trig_s;
         end
         default: begin
            start_s = 1'b0;
         end
      endcase
   end

   // Datapath, counter, edge detect and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q_r    <= 1'b0;
         shreg_r     <= '0;
         acc_r       <= '0;
         cnt_r       <= '0;
         busy_r      <= 1'b0;
         bcd_r       <= '0;
         bcd_valid_r <= 1'b0;
         miss_r      <= 1'b0;
      end else begin
         done_q_r    <= done_in;
         bcd_valid_r <= finish_s;
         miss_r      <= miss_r | miss_set_s;
         if (start_s) begin
            shreg_r <= res_in;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
         end else if (shift_s) begin
            shreg_r <= shreg_sh_s;
            acc_r   <= acc_sh_s;
            cnt_r   <= cnt_r + CNT_W'(1);
         end
         if (finish_s) begin
            bcd_r  <= final_s;
            busy_r <= 1'b0;
         end
      end
   end

   assign busy      = busy_r;
   assign bcd       = bcd_r;
   assign bcd_valid = bcd_valid_r;
   assign miss      = miss_r;
endmodule

// File: tb/tb_res_bcd.sv
// Directed bench for res_bcd; expected BCD words are hand-computed constants.
module tb_res_bcd;
   logic        clk = 1'b0;
   logic        rst;
   logic        done_in;
   logic [31:0] res_in;
   logic        busy;
   logic [39:0] bcd;
   logic        bcd_valid;
   logic        miss;

   int checks = 0;
   int errors = 0;

`ifdef RES_BCD_BLANK_EN
   localparam logic [39:0] EXP_12   = 40'hFFFFFFFF12;
   localparam logic [39:0] EXP_0    = 40'hFFFFFFFFF0;
   localparam logic [39:0] EXP_360  = 40'hFFFFFFF360;
   localparam logic [39:0] EXP_84   = 40'hFFFFFFFF84;
   localparam logic [39:0] EXP_1234 = 40'hFFFFFF1234;
   localparam logic [39:0] EXP_56   = 40'hFFFFFFFF56;
`else
   localparam logic [39:0] EXP_12   = 40'h0000000012;
   localparam logic [39:0] EXP_0    = 40'h0000000000;
   localparam logic [39:0] EXP_360  = 40'h0000000360;
   localparam logic [39:0] EXP_84   = 40'h0000000084;
   localparam logic [39:0] EXP_1234 = 40'h0000001234;
   localparam logic [39:0] EXP_56   = 40'h0000000056;
`endif
   localparam logic [39:0] EXP_MAX  = 40'h4294967295;

   res_bcd dut (
      .clk       (clk),
      .rst       (rst),
      .done_in   (done_in),
      .res_in    (res_in),
      .busy      (busy),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .miss      (miss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Low cycle, then rising edge of done_in carrying r; returns just after the capture edge
   task automatic start(input logic [31:0] r);
      done_in = 1'b0;
      tick();
      res_in  = r;
      done_in = 1'b1;
      tick();
   endtask

   // Waits for bcd_valid (bounded); reports cycles taken and busy drops before it
   task automatic wait_valid(output int n, output int busy_low);
      n = 0;
      busy_low = 0;
      while (bcd_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
         if (bcd_valid !== 1'b1 && busy !== 1'b1) busy_low++;
      end
      if (bcd_valid !== 1'b1) chk("valid_timeout", 40'd0, 40'd1);
   endtask

   int n, bl, nv;

   initial begin
      rst = 1'b1; done_in = 1'b0; res_in = 32'd0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", {39'd0, busy}, 40'd0);
      chk("rst_bcd", bcd, 40'd0);
      chk("rst_valid", {39'd0, bcd_valid}, 40'd0);
      chk("rst_miss", {39'd0, miss}, 40'd0);

      // 12, with res_in scrambled during SHIFT
      start(32'd12);
      chk("c12_busy0", {39'd0, busy}, 40'd1);
      res_in = 32'hDEADBEEF;
      wait_valid(n, bl);
      chk("c12_lat", 40'(n), 40'd32);
      chk("c12_busy", 40'(bl), 40'd0);
      chk("c12_bcd", bcd, EXP_12);
      chk("c12_busy_end", {39'd0, busy}, 40'd0);
      tick();
      chk("c12_pulse", {39'd0, bcd_valid}, 40'd0);
      chk("c12_hold", bcd, EXP_12);

      start(32'hFFFFFFFF);
      wait_valid(n, bl);
      chk("cmax_lat", 40'(n), 40'd32);
      chk("cmax_bcd", bcd, EXP_MAX);

      start(32'd0);
      wait_valid(n, bl);
      chk("c0_lat", 40'(n), 40'd32);
      chk("c0_bcd", bcd, EXP_0);

      // done_in held high ~100 cycles: one conversion only
      start(32'd360);
      nv = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bcd_valid === 1'b1) nv++;
      end
      chk("hold_nvalid", 40'(nv), 40'd1);
      chk("hold_bcd", bcd, EXP_360);
      chk("hold_miss", {39'd0, miss}, 40'd0);

      // Re-trigger during SHIFT is ignored and sets miss
      start(32'd84);
      for (int i = 0; i < 9; i++) tick();
      done_in = 1'b0;
      tick();
      done_in = 1'b1; res_in = 32'd7;
      tick();
      done_in = 1'b0;
      wait_valid(n, bl);
      chk("miss_lat", 40'(n), 40'd21);
      chk("miss_bcd", bcd, EXP_84);
      chk("miss_set", {39'd0, miss}, 40'd1);

      // Trigger in the bcd_valid cycle is accepted: zero idle cycles
      done_in = 1'b1; res_in = 32'd1234;
      tick();
      chk("b2b_busy", {39'd0, busy}, 40'd1);
      wait_valid(n, bl);
      chk("b2b_lat", 40'(n), 40'd32);
      chk("b2b_bcd", bcd, EXP_1234);
      chk("miss_sticky", {39'd0, miss}, 40'd1);

      // Reset mid-conversion aborts silently
      start(32'd999);
      for (int i = 0; i < 15; i++) tick();
      rst = 1'b1; done_in = 1'b0;
      tick();
      rst = 1'b0;
      chk("abort_busy", {39'd0, busy}, 40'd0);
      chk("abort_bcd", bcd, 40'd0);
      chk("abort_miss", {39'd0, miss}, 40'd0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bcd_valid === 1'b1) nv++;
      end
      chk("abort_nvalid", 40'(nv), 40'd0);
      chk("abort_bcd_hold", bcd, 40'd0);

      start(32'd56);
      wait_valid(n, bl);
      chk("post_lat", 40'(n), 40'd32);
      chk("post_bcd", bcd, EXP_56);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
